// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: aluop codes, result
// select, FSM states and the decoded M-extension op.
package ex_muldiv_pkg;

    localparam logic [7:0] EXE_MUL_OP    = 8'hA0;
    localparam logic [7:0] EXE_MULH_OP   = 8'hA1;
    localparam logic [7:0] EXE_MULHSU_OP = 8'hA2;
    localparam logic [7:0] EXE_MULHU_OP  = 8'hA3;
    localparam logic [7:0] EXE_DIV_OP    = 8'hA4;
    localparam logic [7:0] EXE_DIVU_OP   = 8'hA5;
    localparam logic [7:0] EXE_REM_OP    = 8'hA6;
    localparam logic [7:0] EXE_REMU_OP   = 8'hA7;

    localparam logic [2:0] EXE_RES_MULDIV = 3'b110;
    localparam logic [4:0] NOPRegAddr     = 5'b00000;

    typedef enum logic [1:0] {MdIdle, MdMul, MdDiv, MdDone} md_state_e;

    // Low three aluop bits of the M-ext codes map straight onto this enum.
    typedef enum logic [2:0] {
        MdOpMul, MdOpMulh, MdOpMulhsu, MdOpMulhu,
        MdOpDiv, MdOpDivu, MdOpRem, MdOpRemu
    } md_op_e;

    function automatic logic is_muldiv_op(input logic [7:0] aop);
        return (aop >= EXE_MUL_OP) && (aop <= EXE_REMU_OP);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle. quotient and
// remainder present the value being registered this cycle, valid when done=1.
module ex_muldiv_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    // {partial remainder, remaining dividend bits / quotient bits}
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   divisor_q;
    logic [CntW-1:0]   cnt_q;
    logic              run_q;
    logic [XLEN:0]     partial;
    logic [XLEN:0]     diff;
    logic              ge;

    always_comb begin
        partial  = acc_q[2*XLEN-1:XLEN-1];
        diff     = partial - {1'b0, divisor_q};
        ge       = ~diff[XLEN];
        acc_next = {(ge ? diff[XLEN-1:0] : partial[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    end

    assign done      = run_q && (cnt_q == CntW'(XLEN - 1));
    assign quotient  = acc_next[XLEN-1:0];
    assign remainder = acc_next[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else if (start) begin
            acc_q     <= {{XLEN{1'b0}}, dividend};
            divisor_q <= divisor;
            cnt_q     <= '0;
            run_q     <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M/RV64M unit: multi-cycle multiply and restoring divide that
// stalls the front of the pipeline and drives the shared result/forward buses.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned AOP_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [AOP_W-1:0] aluop_i,
    input  logic [XLEN-1:0]  reg1_i,
    input  logic [XLEN-1:0]  reg2_i,
    input  logic [4:0]       wd_i,
    input  logic             wreg_i,
    output logic [4:0]       wd_o,
    output logic             wreg_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic             ex_wreg_o,
    output logic [4:0]       ex_wd_o,
    output logic [XLEN-1:0]  ex_wdata_o,
    output logic             stallreq,
    output logic             busy
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q;
    md_op_e          op_q;
    logic [XLEN-1:0] a_q, b_q, result_q;
    logic [4:0]      wd_q;
    logic            wreg_q, neg_quo_q, neg_rem_q;
    logic [CntW-1:0] cnt_q;

    // Issue-cycle decode
    logic [7:0]      op_code;
    logic            is_m, is_div_in, is_rem_in, signed_div_in;
    logic            a_neg, b_neg, div_zero, div_ovf, div_start;
    md_op_e          op_in;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    always_comb begin
        op_code       = 8'(aluop_i);
        is_m          = is_muldiv_op(op_code) && (AOP_W'(op_code) == aluop_i);
        op_in         = md_op_e'(op_code[2:0]);
        is_div_in     = op_code[2];
        is_rem_in     = (op_in == MdOpRem) || (op_in == MdOpRemu);
        signed_div_in = (op_in == MdOpDiv) || (op_in == MdOpRem);
        a_neg         = signed_div_in && reg1_i[XLEN-1];
        b_neg         = signed_div_in && reg2_i[XLEN-1];
        abs_a         = a_neg ? -reg1_i : reg1_i;
        abs_b         = b_neg ? -reg2_i : reg2_i;
        div_zero      = (reg2_i == '0);
        div_ovf       = signed_div_in && (reg1_i == IntMin) && (reg2_i == '1);
        if (div_zero) begin
            special_res = is_rem_in ? reg1_i : '1;
        end else begin
            special_res = is_rem_in ? '0 : reg1_i;
        end
        div_start = (state_q == MdIdle) && is_m && is_div_in && !div_zero && !div_ovf
                    && !flush;
    end

    // Multiply datapath on the latched operands
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] a_ext, b_ext, product;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_a_signed = (op_q == MdOpMulh) || (op_q == MdOpMulhsu);
        mul_b_signed = (op_q == MdOpMulh);
        a_ext        = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
        b_ext        = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
        product      = a_ext * b_ext;
        mul_res      = (op_q == MdOpMul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    logic            div_done;
    logic [XLEN-1:0] uquo, urem, div_res;

    ex_muldiv_div_iter #(
        .XLEN(XLEN)
    ) u_div_iter (
        .clk      (clk),
        .rst      (rst || flush),
        .start    (div_start),
        .dividend (abs_a),
        .divisor  (abs_b),
        .done     (div_done),
        .quotient (uquo),
        .remainder(urem)
    );

    always_comb begin
        if ((op_q == MdOpRem) || (op_q == MdOpRemu)) begin
            div_res = neg_rem_q ? -urem : urem;
        end else begin
            div_res = neg_quo_q ? -uquo : uquo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MdIdle;
            op_q      <= MdOpMul;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            wd_q      <= NOPRegAddr;
            wreg_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    if (is_m) begin
                        op_q      <= op_in;
                        a_q       <= reg1_i;
                        b_q       <= reg2_i;
                        wd_q      <= wd_i;
                        wreg_q    <= wreg_i;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (!is_div_in) begin
                            cnt_q   <= CntW'(MUL_CYCLES - 1);
                            state_q <= MdMul;
                        end else if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= MdDone;
                        end else begin
                            state_q <= MdDiv;
                        end
                    end
                end
                MdMul: begin
                    if (cnt_q == '0) begin
                        result_q <= mul_res;
                        state_q  <= MdDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MdDiv: begin
                    if (div_done) begin
                        result_q <= div_res;
                        state_q  <= MdDone;
                    end
                end
                MdDone:  state_q <= MdIdle;
                default: state_q <= MdIdle;
            endcase
        end
    end

    logic done_now;
    assign done_now   = (state_q == MdDone) && !flush;
    assign wd_o       = done_now ? wd_q : NOPRegAddr;
    assign ex_wd_o    = done_now ? wd_q : NOPRegAddr;
    assign wreg_o     = done_now && wreg_q;
    assign ex_wreg_o  = done_now && wreg_q;
    assign wdata_o    = done_now ? result_q : '0;
    assign ex_wdata_o = done_now ? result_q : '0;
    assign stallreq   = !flush && ((state_q == MdMul) || (state_q == MdDiv) ||
                                   ((state_q == MdIdle) && is_m));
    assign busy       = (state_q != MdIdle);

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised execute-stage extension implementing the RV32M/RV64M multiply/divide ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the existing ALU in EX, fed by id_ex, and drives the same wd/wreg/wdata result and forwarding buses.
- Unlike the single-cycle ALU path, ops are multi-cycle: the block raises stallreq to ctrl, which freezes pc/if_id/id_ex while the unit iterates.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_CYCLES, 2, cycles spent in MUL state (>=1). The product is registered after MUL_CYCLES.
- AOP_W, 8, aluop bus width (matches the decoder).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush (branch/exception); abandons current op
- aluop_i  in  AOP_W  decoded op; only the 8 M-ext encodings are acted on
- reg1_i  in  XLEN  rs1 value (dividend / multiplicand)
- reg2_i  in  XLEN  rs2 value (divisor / multiplier)
- wd_i  in  5  destination register
- wreg_i  in  1  write-enable from decoder
- wd_o  out  5  destination to ex_mem
- wreg_o  out  1  write-enable to ex_mem
- wdata_o  out  XLEN  result to ex_mem
- ex_wreg_o  out  1  forwarding to id
- ex_wd_o  out  5  forwarding to id
- ex_wdata_o  out  XLEN  forwarding to id
- stallreq  out  1  stall request to ctrl
- busy  out  1  state != IDLE (debug/perf counter)

Behaviour:
- Reset: state=IDLE; all outputs 0; wd_o/ex_wd_o=NOPRegAddr; internal accumulators 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Non-M op: all outputs 0, stallreq=0.
  - M op: latch operands, op and wd/wreg; stallreq=1 combinationally in this cycle.
  - Next state: MUL for mul ops, DIV for div/rem ops.
  - Div special cases go straight to DONE:
    - divisor==0: quotient = all ones; remainder = dividend.
    - Signed overflow (dividend = 1<<(XLEN-1), divisor = -1): quotient = dividend; remainder = 0.
- MUL:
  - Compute the 2*XLEN product of sign/zero-extended operands (signed x signed for MULH, signed x unsigned for MULHSU, unsigned x unsigned otherwise).
  - Counter runs MUL_CYCLES-1 down to 0, then go to DONE.
  - MUL returns low XLEN bits; the MULH* ops return high XLEN bits.
  - stallreq=1 throughout.
- DIV:
  - Radix-2 restoring divide on absolute values; one quotient bit per cycle; cnt 0..XLEN-1; then go to DONE.
  - Signed fixup on the final cycle: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - stallreq=1 throughout.
- DONE:
  - stallreq=0.
  - wd_o/ex_wd_o = latched wd; wreg_o/ex_wreg_o = latched wreg; wdata_o/ex_wdata_o = result register.
  - Always return to IDLE next cycle. The pipeline advances on this edge, so the same instruction is never re-issued.
- Latency in EX, counted from the IDLE issue cycle to the DONE cycle inclusive:
  - mul: MUL_CYCLES+2.
  - div: XLEN+2.
  - div special cases: 2.
- Operands are latched at issue; reg1_i/reg2_i changes during iteration are ignored.
- flush (any state): next state IDLE, counters cleared, stallreq deasserted in the same cycle, outputs zeroed. No writeback of the abandoned op.
- rst has priority over flush; rst mid-operation returns to IDLE with reset outputs next cycle.
- Widths: 2*XLEN-bit product and partial remainder; counter width $clog2(XLEN)+1.
- No back-to-back issue: after DONE there is always one IDLE cycle, taken by the next instruction's arrival.

Decomposition:
- Shared define.v additions:
  - EXE_MUL_OP … EXE_REMU_OP aluop encodings.
  - EXE_RES_MULDIV alusel code.
  - Muldiv state encodings: MD_IDLE, MD_MUL, MD_DIV, MD_DONE.
- One natural sub-module: div_iter.
  - Function: unsigned restoring divider.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Contents: counter and shift registers.
- Sign handling and the mul datapath stay in ex_muldiv.

Test Plan:
- MUL 7 x -3 (XLEN=32, MUL_CYCLES=2) -> stallreq high 3 cycles, DONE cycle wdata_o=0xFFFFFFEB, wreg_o=1, wd_o as issued.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wdata_o=0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> exactly 34 cycles in EX, quotient 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU x / 0 -> 2 cycles, 0xFFFFFFFF; REM 5 % 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
- flush asserted at cycle 10 of a DIV -> stallreq low same cycle, state IDLE next cycle, no wreg_o pulse; next ADD-class op passes untouched (all outputs 0 from this block).
- rst held 1 cycle mid-MUL -> all outputs 0, busy=0 next cycle. Repeat with XLEN=64: DIVU 2^63 / 3 -> 0x2AAAAAAAAAAAAAAA, REMU -> 2.
